// File: rtl/dvi_pkg.sv
// Shared types and TMDS control-token constants for the DVI receive alignment path.
package dvi_pkg;

  localparam int NUM_CH = 3;

  typedef logic [9:0] tmds_word_t;

  localparam tmds_word_t TMDS_CTRL_00 = 10'b1101010100;
  localparam tmds_word_t TMDS_CTRL_01 = 10'b0010101011;
  localparam tmds_word_t TMDS_CTRL_10 = 10'b0101010100;
  localparam tmds_word_t TMDS_CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} align_state_t;

  function automatic logic is_ctrl_token(input tmds_word_t w);
    return (w == TMDS_CTRL_00) || (w == TMDS_CTRL_01) ||
           (w == TMDS_CTRL_10) || (w == TMDS_CTRL_11);
  endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Single-channel word-alignment FSM: hunts for control tokens, bitslips on timeout.
// Loss-of-lock statistics counter built only when DVI_RX_ALIGN_STAT_EN is defined.
module tmds_align_fsm
  import dvi_pkg::*;
#(
  parameter int LOCK_CNT      = 64,
  parameter int TOKEN_TIMEOUT = 4096,
  parameter int SLIP_WAIT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  tmds_word_t  word,
  output logic        slip,
  output logic        locked,
  output logic [15:0] lol_cnt
);

  align_state_t state, state_nxt;
  logic [15:0]  tok_cnt, to_cnt;
  logic [7:0]   wait_cnt;
  logic [3:0]   slip_idx;
  logic         tok, lock_hit, timeout;

  assign tok      = is_ctrl_token(word);
  assign lock_hit = tok && (tok_cnt == 16'(LOCK_CNT - 1));
  assign timeout  = !tok && (to_cnt == 16'(TOKEN_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: begin
        if (lock_hit)     state_nxt = LOCKED;
        else if (timeout) state_nxt = SLIP;
      end
      SLIP:   state_nxt = WAIT;
      WAIT:   if (wait_cnt == 8'(SLIP_WAIT - 1)) state_nxt = SEARCH;
      LOCKED: if (timeout) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
    if (!en) state_nxt = SEARCH;
  end

  // Every state change starts the new state with fresh counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_cnt  <= '0;
      to_cnt   <= '0;
      wait_cnt <= '0;
    end else if (!en || state_nxt != state) begin
      tok_cnt  <= '0;
      to_cnt   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        SEARCH: begin
          if (tok) begin
            tok_cnt <= tok_cnt + 16'd1;
            to_cnt  <= '0;
          end else begin
            to_cnt  <= to_cnt + 16'd1;
          end
        end
        WAIT:   wait_cnt <= wait_cnt + 8'd1;
        LOCKED: to_cnt   <= tok ? '0 : to_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              slip_idx <= '0;
    else if (state == SLIP)  slip_idx <= (slip_idx == 4'd9) ? 4'd0 : slip_idx + 4'd1;
  end

  always_comb begin
    slip   = (state == SLIP);
    locked = (state == LOCKED);
  end

`ifdef DVI_RX_ALIGN_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lol_cnt <= '0;
    else if (en && state == LOCKED && timeout && lol_cnt != 16'hFFFF)
      lol_cnt <= lol_cnt + 16'd1;
  end
`else
  assign lol_cnt = '0;
`endif

endmodule

// File: rtl/dvi_rx_align_ctrl.sv
// Three-channel TMDS word-alignment controller; one tmds_align_fsm per channel.
// Optional loss-of-lock counters: define DVI_RX_ALIGN_STAT_EN.
module dvi_rx_align_ctrl
  import dvi_pkg::*;
#(
  parameter int LOCK_CNT      = 64,
  parameter int TOKEN_TIMEOUT = 4096,
  parameter int SLIP_WAIT     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic [NUM_CH-1:0][9:0]   par_data_i,
  output logic [NUM_CH-1:0]        slip_o,
  output logic [NUM_CH-1:0]        locked_o,
  output logic                     aligned_o,
  output logic [NUM_CH-1:0][15:0]  lol_cnt_o
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    tmds_align_fsm #(
      .LOCK_CNT      (LOCK_CNT),
      .TOKEN_TIMEOUT (TOKEN_TIMEOUT),
      .SLIP_WAIT     (SLIP_WAIT)
    ) u_fsm (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .en      (en_i),
      .word    (par_data_i[n]),
      .slip    (slip_o[n]),
      .locked  (locked_o[n]),
      .lol_cnt (lol_cnt_o[n])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) aligned_o <= 1'b0;
    else          aligned_o <= &locked_o;
  end

endmodule
